ycbcr422_to_rgb888: RTL and testbench

- AXI4-Stream stage directly downstream of the BT.656 receiver, in the PCLK domain.
- Consumes the 8-bit YCbCr 4:2:2 sample stream (Cb0 Y0 Cr0 Y1 ...) and emits one 24-bit RGB888 pixel per luma sample, using BT.601 limited-range conversion.
- Preserves SOF (tuser) and EOL (tlast) framing.
- Honours backpressure and reports framing errors for the AXI4-Lite status register.

---
 rtl/video_pkg.sv | 26 ++
 rtl/ycbcr422_to_rgb888_if.sv | 13 +
 rtl/ycbcr_to_rgb_pipe.sv | 85 ++++++++
 rtl/ycbcr422_to_rgb888.sv | 170 +++++++++++++++++
 tb/tb_ycbcr422_to_rgb888.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/video_pkg.sv
// Shared constants and types for the YCbCr 4:2:2 to RGB888 conversion stage.
package video_pkg;

    // BT.601 limited-range coefficients, scaled by 256
    localparam int unsigned C_Y   = 298;
    localparam int unsigned C_RV  = 409;
    localparam int unsigned C_GU  = 100;
    localparam int unsigned C_GV  = 208;
    localparam int unsigned C_BU  = 516;
    localparam int unsigned Y_OFS = 16;
    localparam int unsigned C_OFS = 128;

    typedef enum logic [1:0] {
        PH_CB = 2'd0,
        PH_Y0 = 2'd1,
        PH_CR = 2'd2,
        PH_Y1 = 2'd3
    } phase_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

endpackage

// File: rtl/ycbcr422_to_rgb888_if.sv
// AXI4-Stream style bundle with SOF (tuser) and EOL (tlast) sideband.
interface ycbcr422_to_rgb888_if #(
    parameter int unsigned DW = 8
);
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tready;
    logic          tuser;
    logic          tlast;

    modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);
endinterface

// File: rtl/ycbcr_to_rgb_pipe.sv
// Three-stage BT.601 YCbCr to RGB arithmetic; every stage advances only on ce.
module ycbcr_to_rgb_pipe
    import video_pkg::*;
(
    input  logic       clk,
    input  logic       clr_n,
    input  logic       ce,
    input  logic       in_valid,
    input  logic       in_user,
    input  logic       in_last,
    input  logic [7:0] in_y,
    input  logic [7:0] in_cb,
    input  logic [7:0] in_cr,
    output logic       out_valid,
    output logic       out_user,
    output logic       out_last,
    output rgb888_t    out_rgb
);

    localparam logic signed [19:0] K_Y  = 20'(C_Y);
    localparam logic signed [19:0] K_RV = 20'(C_RV);
    localparam logic signed [19:0] K_GU = 20'(C_GU);
    localparam logic signed [19:0] K_GV = 20'(C_GV);
    localparam logic signed [19:0] K_BU = 20'(C_BU);
    localparam logic signed [19:0] RND  = 20'sd128;

    logic              s1_valid, s1_user, s1_last;
    logic signed [9:0] s1_y, s1_cb, s1_cr;
    logic              s2_valid, s2_user, s2_last;
    logic signed [19:0] s2_r, s2_g, s2_b;

    // Round, scale down by 256 and saturate to an 8-bit channel
    function automatic logic [7:0] clamp8(input logic signed [19:0] v);
        logic signed [19:0] t;
        t = (v + RND) >>> 8;
        if (t[19])
            clamp8 = 8'h00;
        else if (t > 20'sd255)
            clamp8 = 8'hFF;
        else
            clamp8 = t[7:0];
    endfunction

    // Stage 1: remove offsets; stage 2: weighted sums; stage 3: clamp to output
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            s1_valid  <= 1'b0;
            s1_user   <= 1'b0;
            s1_last   <= 1'b0;
            s1_y      <= '0;
            s1_cb     <= '0;
            s1_cr     <= '0;
            s2_valid  <= 1'b0;
            s2_user   <= 1'b0;
            s2_last   <= 1'b0;
            s2_r      <= '0;
            s2_g      <= '0;
            s2_b      <= '0;
            out_valid <= 1'b0;
            out_user  <= 1'b0;
            out_last  <= 1'b0;
            out_rgb   <= '0;
        end else if (ce) begin
            s1_valid  <= in_valid;
            s1_user   <= in_user;
            s1_last   <= in_last;
            s1_y      <= $signed({2'b00, in_y}  - 10'(Y_OFS));
            s1_cb     <= $signed({2'b00, in_cb} - 10'(C_OFS));
            s1_cr     <= $signed({2'b00, in_cr} - 10'(C_OFS));

            s2_valid  <= s1_valid;
            s2_user   <= s1_user;
            s2_last   <= s1_last;
            s2_r      <= K_Y * 20'(s1_y) + K_RV * 20'(s1_cr);
            s2_g      <= K_Y * 20'(s1_y) - K_GU * 20'(s1_cb) - K_GV * 20'(s1_cr);
            s2_b      <= K_Y * 20'(s1_y) + K_BU * 20'(s1_cb);

            out_valid <= s2_valid;
            out_user  <= s2_user;
            out_last  <= s2_last;
            out_rgb   <= '{r: clamp8(s2_r), g: clamp8(s2_g), b: clamp8(s2_b)};
        end
    end

endmodule

// File: rtl/ycbcr422_to_rgb888.sv
// YCbCr 4:2:2 sample stream to RGB888 pixel stream with SOF/EOL framing and error count.
module ycbcr422_to_rgb888
    import video_pkg::*;
#(
    parameter int unsigned ERR_W = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 enable_i,
    ycbcr422_to_rgb888_if.slave  s,
    ycbcr422_to_rgb888_if.master m,
    input  logic                 err_clr_i,
    output logic [ERR_W-1:0]     err_cnt_o,
    output logic                 synced_o
);

    phase_t     phase_q, phase_d;
    logic       live_c;
    logic       ce_c, acc_c;
    logic       synced_q, synced_d;
    logic       sof_q, sof_d;
    logic       err_c;
    logic       lat_cb_c, lat_y0_c, lat_cr_c;
    logic [7:0] cb_q, y0_q, cr_q;

    logic       issue_c, tok_user_d, tok_last_d;
    logic [7:0] tok_y_d, tok_cb_d, tok_cr_d;
    logic       tok_valid_q, tok_user_q, tok_last_q;
    logic [7:0] tok_y_q, tok_cb_q, tok_cr_q;

    logic       p_valid, p_user, p_last;
    rgb888_t    p_rgb;

    assign live_c   = rstn & enable_i;
    assign ce_c     = m.tready | ~p_valid;
    assign s.tready = enable_i & ce_c;
    assign acc_c    = s.tvalid & enable_i & ce_c;
    assign synced_o = synced_q;

    // Phase register; enable low behaves like reset
    always_ff @(posedge clk) begin
        if (!live_c)
            phase_q <= PH_CB;
        else
            phase_q <= phase_d;
    end

    // Next phase, sync, framing errors, group latching and pixel issue
    always_comb begin
        phase_d    = phase_q;
        synced_d   = synced_q;
        sof_d      = sof_q;
        err_c      = 1'b0;
        lat_cb_c   = 1'b0;
        lat_y0_c   = 1'b0;
        lat_cr_c   = 1'b0;
        issue_c    = 1'b0;
        tok_y_d    = s.tdata;
        tok_cb_d   = cb_q;
        tok_cr_d   = cr_q;
        tok_user_d = 1'b0;
        tok_last_d = 1'b0;
        // Unsynced samples are dropped; phase is always PH_CB while unsynced
        if (acc_c && (synced_q || s.tuser)) begin
            if (s.tuser)
                synced_d = 1'b1;
            if (s.tuser && s.tlast && phase_q == PH_CB) begin
                err_c   = 1'b1;
                phase_d = PH_CB;
            end else if (s.tuser) begin
                // SOF restarts the group; a partial group is silently dropped
                err_c    = (phase_q != PH_CB);
                lat_cb_c = 1'b1;
                sof_d    = 1'b1;
                phase_d  = PH_Y0;
            end else if (s.tlast && phase_q != PH_Y1) begin
                err_c   = 1'b1;
                phase_d = PH_CB;
            end else begin
                unique case (phase_q)
                    PH_CB: begin
                        lat_cb_c = 1'b1;
                        sof_d    = 1'b0;
                        phase_d  = PH_Y0;
                    end
                    PH_Y0: begin
                        lat_y0_c = 1'b1;
                        phase_d  = PH_CR;
                    end
                    PH_CR: begin
                        lat_cr_c   = 1'b1;
                        issue_c    = 1'b1;
                        tok_y_d    = y0_q;
                        tok_cr_d   = s.tdata;
                        tok_user_d = sof_q;
                        phase_d    = PH_Y1;
                    end
                    PH_Y1: begin
                        issue_c    = 1'b1;
                        tok_last_d = s.tlast;
                        phase_d    = PH_CB;
                    end
                endcase
            end
        end
    end

    // Sync flag, latched chroma/luma and the issue token feeding the pipe
    always_ff @(posedge clk) begin
        if (!live_c) begin
            synced_q    <= 1'b0;
            sof_q       <= 1'b0;
            cb_q        <= '0;
            y0_q        <= '0;
            cr_q        <= '0;
            tok_valid_q <= 1'b0;
            tok_user_q  <= 1'b0;
            tok_last_q  <= 1'b0;
            tok_y_q     <= '0;
            tok_cb_q    <= '0;
            tok_cr_q    <= '0;
        end else begin
            synced_q <= synced_d;
            sof_q    <= sof_d;
            if (lat_cb_c) cb_q <= s.tdata;
            if (lat_y0_c) y0_q <= s.tdata;
            if (lat_cr_c) cr_q <= s.tdata;
            if (ce_c) begin
                tok_valid_q <= issue_c;
                tok_user_q  <= tok_user_d;
                tok_last_q  <= tok_last_d;
                tok_y_q     <= tok_y_d;
                tok_cb_q    <= tok_cb_d;
                tok_cr_q    <= tok_cr_d;
            end
        end
    end

    // Saturating framing-error counter; a clear coinciding with an error leaves 1
    always_ff @(posedge clk) begin
        if (!rstn)
            err_cnt_o <= '0;
        else if (err_clr_i)
            err_cnt_o <= ERR_W'(err_c);
        else if (err_c && (err_cnt_o != '1))
            err_cnt_o <= err_cnt_o + 1'b1;
    end

    ycbcr_to_rgb_pipe u_pipe (
        .clk       (clk),
        .clr_n     (live_c),
        .ce        (ce_c),
        .in_valid  (tok_valid_q),
        .in_user   (tok_user_q),
        .in_last   (tok_last_q),
        .in_y      (tok_y_q),
        .in_cb     (tok_cb_q),
        .in_cr     (tok_cr_q),
        .out_valid (p_valid),
        .out_user  (p_user),
        .out_last  (p_last),
        .out_rgb   (p_rgb)
    );

    assign m.tvalid = p_valid;
    assign m.tuser  = p_user;
    assign m.tlast  = p_last;
    assign m.tdata  = p_rgb;

endmodule

// File: tb/tb_ycbcr422_to_rgb888.sv
// Directed and table-driven bench for ycbcr422_to_rgb888.
module tb_ycbcr422_to_rgb888;

    logic        clk = 1'b0;
    logic        rstn;
    logic        enable_i;
    logic        err_clr_i;
    logic [15:0] err_cnt_o;
    logic        synced_o;

    ycbcr422_to_rgb888_if #(.DW(8))  s_if ();
    ycbcr422_to_rgb888_if #(.DW(24)) m_if ();

    ycbcr422_to_rgb888 #(.ERR_W(16)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .enable_i  (enable_i),
        .s         (s_if),
        .m         (m_if),
        .err_clr_i (err_clr_i),
        .err_cnt_o (err_cnt_o),
        .synced_o  (synced_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [23:0] d;
        logic        u;
        logic        l;
    } pix_t;

    typedef struct {
        logic [7:0]  cb, y0, cr, y1;
        logic        u, l;
        logic [23:0] e0, e1;
    } vec_t;

    int   checks   = 0;
    int   failures = 0;
    pix_t got_q[$];
    pix_t exp_q[$];
    logic rand_rdy = 1'b0;
    logic stab_en  = 1'b1;
    logic prev_stall = 1'b0;
    logic [26:0] prev_bus = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, act, exp);
        end
    endtask

    // Output collector and stall-hold checker, sampled mid-cycle
    always @(negedge clk) begin
        if (stab_en && prev_stall)
            chk("stall_hold", 32'({m_if.tvalid, m_if.tdata, m_if.tuser, m_if.tlast}), 32'(prev_bus));
        prev_stall <= m_if.tvalid & ~m_if.tready;
        prev_bus   <= {m_if.tvalid, m_if.tdata, m_if.tuser, m_if.tlast};
        if (m_if.tvalid && m_if.tready)
            got_q.push_back('{d: m_if.tdata, u: m_if.tuser, l: m_if.tlast});
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_rdy) m_if.tready = 1'($urandom_range(0, 1));
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic u, input logic l);
        int n = 0;
        s_if.tdata  = d;
        s_if.tuser  = u;
        s_if.tlast  = l;
        s_if.tvalid = 1'b1;
        while (!s_if.tready && n < 1000) begin
            step();
            n++;
        end
        if (!s_if.tready) chk("send_ready", 32'(s_if.tready), 32'd1);
        step();
        s_if.tvalid = 1'b0;
        s_if.tuser  = 1'b0;
        s_if.tlast  = 1'b0;
    endtask

    task automatic send_group(input logic [7:0] cb, y0, cr, y1, input logic u, l);
        send(cb, u, 1'b0);
        send(y0, 1'b0, 1'b0);
        send(cr, 1'b0, 1'b0);
        send(y1, 1'b0, l);
    endtask

    task automatic wait_pix(input int n);
        int k = 0;
        while (got_q.size() < n && k < 2000) begin
            step();
            k++;
        end
        chk("pix_count", 32'(got_q.size()), 32'(n));
    endtask

    task automatic chk_pop(input string nm, input logic [23:0] d, input logic u, input logic l);
        pix_t p;
        if (got_q.size() == 0) begin
            chk({nm, "_present"}, 32'd0, 32'd1);
        end else begin
            p = got_q.pop_front();
            chk(nm, 32'(p), 32'({d, u, l}));
        end
    endtask

    function automatic int clip(input int v);
        if (v < 0) return 0;
        if (v > 255) return 255;
        return v;
    endfunction

    function automatic logic [23:0] model(input int yy, input int ub, input int vr);
        int y, u, v, r, g, b;
        y = yy - 16;
        u = ub - 128;
        v = vr - 128;
        r = clip((298 * y + 409 * v + 128) >>> 8);
        g = clip((298 * y - 100 * u - 208 * v + 128) >>> 8);
        b = clip((298 * y + 516 * u + 128) >>> 8);
        return {8'(r), 8'(g), 8'(b)};
    endfunction

    vec_t tbl[5];

    initial begin
        tbl[0] = '{cb: 8'd128, y0: 8'd235, cr: 8'd128, y1: 8'd16,  u: 1'b1, l: 1'b0, e0: 24'hFFFFFF, e1: 24'h000000};
        tbl[1] = '{cb: 8'd90,  y0: 8'd81,  cr: 8'd240, y1: 8'd81,  u: 1'b0, l: 1'b1, e0: 24'hFF0000, e1: 24'hFF0000};
        tbl[2] = '{cb: 8'd128, y0: 8'd255, cr: 8'd255, y1: 8'd255, u: 1'b0, l: 1'b0, e0: 24'hFFAFFF, e1: 24'hFFAFFF};
        tbl[3] = '{cb: 8'd128, y0: 8'd126, cr: 8'd128, y1: 8'd180, u: 1'b0, l: 1'b0, e0: 24'h808080, e1: 24'hBFBFBF};
        tbl[4] = '{cb: 8'd255, y0: 8'd128, cr: 8'd128, y1: 8'd128, u: 1'b0, l: 1'b0, e0: 24'h8251FF, e1: 24'h8251FF};

        rstn        = 1'b0;
        enable_i    = 1'b0;
        err_clr_i   = 1'b0;
        s_if.tdata  = '0;
        s_if.tvalid = 1'b0;
        s_if.tuser  = 1'b0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b1;

        // Reset state
        repeat (3) step();
        chk("rst_tready", 32'(s_if.tready), 32'd0);
        chk("rst_tvalid", 32'(m_if.tvalid), 32'd0);
        chk("rst_tdata",  32'(m_if.tdata),  32'd0);
        chk("rst_synced", 32'(synced_o),    32'd0);
        chk("rst_err",    32'(err_cnt_o),   32'd0);
        rstn     = 1'b1;
        enable_i = 1'b1;
        step();

        // First group: exact latency from the Cr accept
        send(8'd128, 1'b1, 1'b0);
        send(8'd235, 1'b0, 1'b0);
        send(8'd128, 1'b0, 1'b0);
        chk("lat_c0", 32'(m_if.tvalid), 32'd0);
        send(8'd16, 1'b0, 1'b0);
        chk("lat_c1", 32'(m_if.tvalid), 32'd0);
        step();
        chk("lat_c2", 32'(m_if.tvalid), 32'd0);
        step();
        chk("lat_c3", 32'({m_if.tvalid, m_if.tdata, m_if.tuser, m_if.tlast}), 32'({1'b1, 24'hFFFFFF, 1'b1, 1'b0}));
        step();
        chk("lat_c4", 32'({m_if.tvalid, m_if.tdata, m_if.tuser, m_if.tlast}), 32'({1'b1, 24'h000000, 1'b0, 1'b0}));
        step();
        chk("first_synced", 32'(synced_o), 32'd1);
        chk("first_err", 32'(err_cnt_o), 32'd0);
        got_q.delete();

        // Table of directed groups
        for (int i = 0; i < 5; i++) begin
            send_group(tbl[i].cb, tbl[i].y0, tbl[i].cr, tbl[i].y1, tbl[i].u, tbl[i].l);
            wait_pix(2);
            chk_pop($sformatf("row%0d_p0", i), tbl[i].e0, tbl[i].u, 1'b0);
            chk_pop($sformatf("row%0d_p1", i), tbl[i].e1, 1'b0, tbl[i].l);
        end
        chk("table_err", 32'(err_cnt_o), 32'd0);

        // 64-pixel line under random backpressure
        rand_rdy = 1'b1;
        for (int g = 0; g < 32; g++) begin
            logic [7:0] cb, y0, cr, y1;
            cb = 8'($urandom_range(0, 255));
            y0 = 8'($urandom_range(0, 255));
            cr = 8'($urandom_range(0, 255));
            y1 = 8'($urandom_range(0, 255));
            exp_q.push_back('{d: model(int'(y0), int'(cb), int'(cr)), u: 1'b0, l: 1'b0});
            exp_q.push_back('{d: model(int'(y1), int'(cb), int'(cr)), u: 1'b0, l: (g == 31)});
            send_group(cb, y0, cr, y1, 1'b0, (g == 31));
        end
        wait_pix(64);
        rand_rdy    = 1'b0;
        m_if.tready = 1'b1;
        repeat (10) step();
        chk("rand_total", 32'(got_q.size()), 32'd64);
        for (int i = 0; i < 64 && exp_q.size() > 0; i++) begin
            pix_t e;
            e = exp_q.pop_front();
            chk_pop($sformatf("rand_px%0d", i), e.d, e.u, e.l);
        end
        got_q.delete();

        // Unsynced samples are discarded
        enable_i = 1'b0;
        step();
        enable_i = 1'b1;
        step();
        chk("unsync_flag0", 32'(synced_o), 32'd0);
        for (int i = 0; i < 6; i++) send(8'(40 + i * 30), 1'b0, 1'b0);
        repeat (6) step();
        chk("unsync_nopix", 32'(got_q.size()), 32'd0);
        chk("unsync_flag1", 32'(synced_o), 32'd0);
        chk("unsync_err", 32'(err_cnt_o), 32'd0);

        // SOF at phase 2 drops the partial group
        send(8'd128, 1'b1, 1'b0);
        send(8'd235, 1'b0, 1'b0);
        send(8'd128, 1'b1, 1'b0);
        step();
        chk("sof_err", 32'(err_cnt_o), 32'd1);
        send(8'd16, 1'b0, 1'b0);
        send(8'd128, 1'b0, 1'b0);
        send(8'd16, 1'b0, 1'b0);
        wait_pix(2);
        chk_pop("sof_p0", 24'h000000, 1'b1, 1'b0);
        chk_pop("sof_p1", 24'h000000, 1'b0, 1'b0);
        repeat (6) step();
        chk("sof_nodrop", 32'(got_q.size()), 32'd0);

        err_clr_i = 1'b1;
        step();
        err_clr_i = 1'b0;
        chk("clr_err", 32'(err_cnt_o), 32'd0);

        // EOL at phase 1, then clear coinciding with another error
        send(8'd128, 1'b0, 1'b0);
        send(8'd235, 1'b0, 1'b1);
        chk("eol_err", 32'(err_cnt_o), 32'd1);
        err_clr_i = 1'b1;
        send(8'd50, 1'b0, 1'b1);
        err_clr_i = 1'b0;
        chk("clr_and_err", 32'(err_cnt_o), 32'd1);
        send_group(8'd128, 8'd235, 8'd128, 8'd235, 1'b0, 1'b0);
        wait_pix(2);
        chk_pop("eol_p0", 24'hFFFFFF, 1'b0, 1'b0);
        chk_pop("eol_p1", 24'hFFFFFF, 1'b0, 1'b0);

        // SOF and EOL together at phase 2: one error, sample becomes Cb
        err_clr_i = 1'b1;
        step();
        err_clr_i = 1'b0;
        send(8'd128, 1'b0, 1'b0);
        send(8'd235, 1'b0, 1'b0);
        send(8'd128, 1'b1, 1'b1);
        send(8'd235, 1'b0, 1'b0);
        send(8'd128, 1'b0, 1'b0);
        send(8'd16, 1'b0, 1'b1);
        wait_pix(2);
        chk("both_err", 32'(err_cnt_o), 32'd1);
        chk_pop("both_p0", 24'hFFFFFF, 1'b1, 1'b0);
        chk_pop("both_p1", 24'h000000, 1'b0, 1'b1);

        // Saturation: EOL at phase 0 every cycle
        err_clr_i = 1'b1;
        step();
        err_clr_i   = 1'b0;
        s_if.tdata  = 8'd0;
        s_if.tuser  = 1'b0;
        s_if.tlast  = 1'b1;
        s_if.tvalid = 1'b1;
        repeat (1000) step();
        chk("sat_mid", 32'(err_cnt_o), 32'd1000);
        repeat (69000) step();
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        step();
        chk("sat_full", 32'(err_cnt_o), 32'hFFFF);
        chk("sat_nopix", 32'(got_q.size()), 32'd0);

        // Enable drop with pixels in flight under stall
        m_if.tready = 1'b0;
        send_group(8'd128, 8'd235, 8'd128, 8'd16, 1'b1, 1'b0);
        send(8'd128, 1'b0, 1'b0);
        send(8'd235, 1'b0, 1'b0);
        chk("stall_tready", 32'(s_if.tready), 32'd0);
        chk("stall_out", 32'({m_if.tvalid, m_if.tdata}), 32'({1'b1, 24'hFFFFFF}));
        step();
        step();
        chk("stall_out2", 32'({m_if.tvalid, m_if.tdata}), 32'({1'b1, 24'hFFFFFF}));
        stab_en  = 1'b0;
        enable_i = 1'b0;
        #1;
        chk("dis_tready", 32'(s_if.tready), 32'd0);
        step();
        chk("dis_tvalid", 32'(m_if.tvalid), 32'd0);
        chk("dis_tdata",  32'(m_if.tdata),  32'd0);
        chk("dis_synced", 32'(synced_o), 32'd0);
        m_if.tready = 1'b1;
        step();
        stab_en  = 1'b1;
        enable_i = 1'b1;
        repeat (6) step();
        chk("reen_nopix", 32'(got_q.size()), 32'd0);
        send_group(8'd128, 8'd235, 8'd128, 8'd235, 1'b0, 1'b0);
        repeat (8) step();
        chk("reen_nosof_pix", 32'(got_q.size()), 32'd0);
        chk("reen_nosof_sync", 32'(synced_o), 32'd0);
        send_group(8'd128, 8'd16, 8'd128, 8'd16, 1'b1, 1'b0);
        wait_pix(2);
        chk_pop("reen_p0", 24'h000000, 1'b1, 1'b0);
        chk_pop("reen_p1", 24'h000000, 1'b0, 1'b0);
        chk("reen_synced", 32'(synced_o), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
